// File: rtl/xge_wb_pkg.sv
// Shared definitions for the xge_mac Wishbone register-port initiator:
// FSM state encoding, MAC register map and the default ack timeout.
package xge_wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD_CYC = 2'd1,
    CMD_RSP = 2'd2,
    IRQ_CYC = 2'd3
  } wb_state_e;

  localparam logic [7:0] ADR_CONFIG0     = 8'h00;
  localparam logic [7:0] ADR_INT_PENDING = 8'h08;
  localparam logic [7:0] ADR_INT_STATUS  = 8'h0C;
  localparam logic [7:0] ADR_INT_MASK    = 8'h10;

  localparam int DEFAULT_TIMEOUT_CYC = 64;

endpackage

// File: rtl/xge_wb_initiator.sv
// Single-transfer Wishbone classic initiator for the xge_mac register port.
// Runs one command cycle at a time and auto-reads INT_PENDING on interrupt.
module xge_wb_initiator
  import xge_wb_pkg::*;
#(
  parameter int         TIMEOUT_CYC  = DEFAULT_TIMEOUT_CYC,
  parameter logic [7:0] INT_PEND_ADR = ADR_INT_PENDING
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [7:0]  cmd_adr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        irq_en,
  output logic        irq_valid,
  output logic [31:0] irq_pending,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_int_i,
  output logic [1:0]  fsm_state
);

  localparam int             CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYC - 1);

  // Handshakes: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready never depends on cmd_valid. The
  // rsp_valid and irq_valid pulses have no back-pressure and last one cycle.

  wb_state_e     state_q, state_d;
  logic [CW-1:0] tmo_cnt;
  logic          irq_armed;
  logic          irq_req;
  logic          in_cyc;
  logic          tmo_hit;
  logic          accept, irq_go;
  logic          ack_cmd, tmo_cmd, ack_irq, cyc_end;

  // Armed again only after the interrupt line has been seen low, so one
  // level interrupt produces exactly one auto-read.
  assign irq_req   = wb_int_i & irq_en & irq_armed;
  assign in_cyc    = (state_q == CMD_CYC) || (state_q == IRQ_CYC);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign fsm_state = state_q;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    irq_go    = 1'b0;
    ack_cmd   = 1'b0;
    tmo_cmd   = 1'b0;
    ack_irq   = 1'b0;
    cyc_end   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (irq_req) begin
          irq_go  = 1'b1;
          state_d = IRQ_CYC;
        end else begin
          cmd_ready = reset_156m25_n;
          if (cmd_valid && reset_156m25_n) begin
            accept  = 1'b1;
            state_d = CMD_CYC;
          end
        end
      end
      CMD_CYC: begin
        if (wb_ack_i) begin
          ack_cmd = 1'b1;
          cyc_end = 1'b1;
          state_d = CMD_RSP;
        end else if (tmo_hit) begin
          tmo_cmd = 1'b1;
          cyc_end = 1'b1;
          state_d = CMD_RSP;
        end
      end
      CMD_RSP: state_d = IDLE;
      IRQ_CYC: begin
        if (wb_ack_i) begin
          ack_irq = 1'b1;
          cyc_end = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          cyc_end = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q   <= IDLE;
      tmo_cnt   <= '0;
      irq_armed <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_cnt <= in_cyc ? tmo_cnt + CW'(1) : '0;
      if (!wb_int_i)
        irq_armed <= 1'b1;
      else if (irq_go)
        irq_armed <= 1'b0;
    end
  end

  // Bus outputs are registered; they are loaded on cycle entry and cleared
  // on exit so nothing stale is left on the bus while idle.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else if (accept) begin
      wb_cyc_o <= 1'b1;
      wb_stb_o <= 1'b1;
      wb_we_o  <= cmd_we;
      wb_adr_o <= cmd_adr;
      wb_dat_o <= cmd_we ? cmd_wdata : '0;
    end else if (irq_go) begin
      wb_cyc_o <= 1'b1;
      wb_stb_o <= 1'b1;
      wb_we_o  <= 1'b0;
      wb_adr_o <= INT_PEND_ADR;
      wb_dat_o <= '0;
    end else if (cyc_end) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      irq_valid   <= 1'b0;
      irq_pending <= '0;
    end else begin
      rsp_valid <= (state_d == CMD_RSP);
      if (ack_cmd) begin
        rsp_rdata <= wb_we_o ? '0 : wb_dat_i;
        rsp_err   <= 1'b0;
      end else if (tmo_cmd) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end else if (state_q == CMD_RSP) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
      irq_valid <= ack_irq;
      if (ack_irq)
        irq_pending <= wb_dat_i;
    end
  end

endmodule

// File: tb/tb_xge_wb_initiator.sv
// Bench for xge_wb_initiator against a small behavioural xge_mac register
// port (registered ack, clear-on-read INT_PENDING, masked level interrupt).
module tb_xge_wb_initiator;
  import xge_wb_pkg::*;

  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_adr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_err, irq_valid;
  logic [31:0] rsp_rdata, irq_pending;
  logic        irq_en = 1'b1;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_ack_i, wb_int_i;
  logic [1:0]  fsm_state;

  xge_wb_initiator #(.TIMEOUT_CYC(TMO), .INT_PEND_ADR(ADR_INT_PENDING)) dut (
    .clk_156m25(clk), .reset_156m25_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .irq_en(irq_en), .irq_valid(irq_valid), .irq_pending(irq_pending),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_int_i(wb_int_i), .fsm_state(fsm_state)
  );

  // ---------------- MAC register port model ----------------
  logic [31:0] regs [0:63];
  logic [31:0] pending = '0;
  logic [31:0] mac_dat = '0;
  logic        mac_ack = 1'b0;
  logic        mac_stall = 1'b0, frame_event = 1'b0, int_hold = 1'b0, stray_ack = 1'b0;

  initial for (int i = 0; i < 64; i++) regs[i] = '0;

  always @(posedge clk) begin
    logic clr;
    clr = 1'b0;
    mac_ack <= 1'b0;
    if (wb_cyc_o && wb_stb_o && !mac_ack && !mac_stall) begin
      mac_ack <= 1'b1;
      if (wb_we_o) begin
        if (wb_adr_o != ADR_INT_PENDING) regs[wb_adr_o[7:2]] <= wb_dat_o;
        mac_dat <= '0;
      end else if (wb_adr_o == ADR_INT_PENDING) begin
        mac_dat <= pending;
        clr = 1'b1;
      end else begin
        mac_dat <= regs[wb_adr_o[7:2]];
      end
    end
    pending <= (clr ? 32'h0 : pending) | {31'h0, frame_event};
  end

  assign wb_dat_i = mac_dat;
  assign wb_ack_i = mac_ack | stray_ack;
  assign wb_int_i = (|(pending & regs[4])) | int_hold;

  // ---------------- monitors ----------------
  int cyc_cnt = 0;
  int rsp_count = 0, irq_count = 0, irq_cyc = 0, bus_starts = 0, irq_reads = 0;
  logic [31:0] irq_last = '0;
  logic cyc_prev = 1'b0;

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (rsp_valid) rsp_count++;
    if (irq_valid) begin
      irq_count++;
      irq_last = irq_pending;
      irq_cyc  = cyc_cnt;
    end
    if (wb_cyc_o && !cyc_prev) begin
      bus_starts++;
      if (wb_adr_o == ADR_INT_PENDING && !wb_we_o) irq_reads++;
    end
    cyc_prev = wb_cyc_o;
  end

  // ---------------- scoreboard ----------------
  int vectors = 0, miscompares = 0;
  logic [32:0] exp_q[$];

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns #1 after the accepting edge.
  task automatic send_cmd(input logic we, input logic [7:0] adr, input logic [31:0] wdata,
                          output logic first_ready, output int acc_cyc);
    int n;
    cmd_we = we; cmd_adr = adr; cmd_wdata = wdata; cmd_valid = 1'b1;
    #1;
    first_ready = cmd_ready;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_wait: cmd_ready=%b required 1 within 100 cycles", cmd_ready);
    end
    @(posedge clk); #1;
    acc_cyc = cyc_cnt;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic got, output logic [31:0] rd, output logic err,
                          output int det_cyc);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk); n++;
    end
    got = rsp_valid; rd = rsp_rdata; err = rsp_err; det_cyc = cyc_cnt;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    vectors++;
    if ({cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, rsp_err, irq_valid} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, rsp_err, irq_valid});
    end
    vectors++;
    if ({wb_adr_o, wb_dat_o, rsp_rdata, irq_pending, fsm_state} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: adr=%h dat=%h rd=%h irq=%h st=%0d required all 0",
               wb_adr_o, wb_dat_o, rsp_rdata, irq_pending, fsm_state);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    logic fr, got, err; logic [31:0] rd; int acc, det; logic [32:0] exp;
    @(negedge clk);
    exp_q.push_back({1'b0, 32'h0});
    send_cmd(1'b1, ADR_CONFIG0, 32'h0000_0001, fr, acc);
    vectors++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o} !== {3'b111, 8'h00, 32'h1}) begin
      miscompares++;
      $display("FAIL write_bus: cyc=%b stb=%b we=%b adr=%h dat=%h required 1 1 1 00 00000001",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o);
    end
    wait_rsp(got, rd, err, det);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || {err, rd} !== exp) begin
      miscompares++;
      $display("FAIL write_rsp: valid=%b err=%b rdata=%h required 1 %b %h", got, err, rd, exp[32], exp[31:0]);
    end
  endtask

  task automatic test_read_latency();
    logic fr, got, err; logic [31:0] rd; int acc, det; logic [32:0] exp;
    @(negedge clk);
    exp_q.push_back({1'b0, 32'h0000_0001});
    send_cmd(1'b0, ADR_CONFIG0, 32'hDEAD_BEEF, fr, acc);
    vectors++;
    if (wb_dat_o !== 32'h0 || wb_we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL read_dat_o: we=%b dat=%h required 0 00000000", wb_we_o, wb_dat_o);
    end
    wait_rsp(got, rd, err, det);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || {err, rd} !== exp) begin
      miscompares++;
      $display("FAIL read_rsp: valid=%b err=%b rdata=%h required 1 %b %h", got, err, rd, exp[32], exp[31:0]);
    end
    vectors++;
    if (det - acc + 1 !== 3) begin
      miscompares++;
      $display("FAIL read_latency: got %0d required 3", det - acc + 1);
    end
  endtask

  task automatic test_timeout();
    logic fr, got, err; logic [31:0] rd; int acc, det, n; logic [32:0] exp;
    @(negedge clk);
    mac_stall = 1'b1;
    exp_q.push_back({1'b1, 32'h0});
    send_cmd(1'b0, 8'hFC, 32'h0, fr, acc);
    n = 0;
    @(negedge clk);
    while (wb_cyc_o && wb_stb_o && n < 200) begin
      n++; @(negedge clk);
    end
    vectors++;
    if (n !== TMO) begin
      miscompares++;
      $display("FAIL timeout_len: cyc high %0d cycles required %0d", n, TMO);
    end
    wait_rsp(got, rd, err, det);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || {err, rd} !== exp) begin
      miscompares++;
      $display("FAIL timeout_rsp: valid=%b err=%b rdata=%h required 1 1 00000000", got, err, rd);
    end
    @(negedge clk);
    mac_stall = 1'b0;
  endtask

  task automatic test_irq_vs_cmd();
    logic fr, got, err; logic [31:0] rd; int acc, det, c0, r0, s0; logic [32:0] exp;
    @(negedge clk);
    exp_q.push_back({1'b0, 32'h0});
    send_cmd(1'b1, ADR_INT_MASK, 32'hFFFF_FFFF, fr, acc);
    wait_rsp(got, rd, err, det);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || {err, rd} !== exp) begin
      miscompares++;
      $display("FAIL mask_rsp: valid=%b err=%b rdata=%h required 1 0 00000000", got, err, rd);
    end
    c0 = irq_count; r0 = irq_reads;
    @(negedge clk); frame_event = 1'b1;
    @(negedge clk); frame_event = 1'b0;
    exp_q.push_back({1'b0, 32'h0000_0001});
    send_cmd(1'b0, ADR_CONFIG0, 32'h0, fr, acc);
    vectors++;
    if (fr !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_wins_ready: cmd_ready=%b required 0", fr);
    end
    wait_rsp(got, rd, err, det);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || {err, rd} !== exp) begin
      miscompares++;
      $display("FAIL irq_cmd_rsp: valid=%b err=%b rdata=%h required 1 0 00000001", got, err, rd);
    end
    s0 = det;
    repeat (6) @(negedge clk);
    vectors++;
    if (irq_count - c0 !== 1 || irq_last !== 32'h1 || irq_cyc >= s0) begin
      miscompares++;
      $display("FAIL irq_first: count=%0d pending=%h irq_cyc=%0d rsp_cyc=%0d required 1 00000001 irq<rsp",
               irq_count - c0, irq_last, irq_cyc, s0);
    end
    vectors++;
    if (irq_reads - r0 !== 1) begin
      miscompares++;
      $display("FAIL irq_single_read: got %0d reads required 1", irq_reads - r0);
    end
  endtask

  task automatic test_irq_enable();
    int s0, c0, r0;
    @(negedge clk);
    irq_en = 1'b0;
    s0 = bus_starts; c0 = irq_count; r0 = irq_reads;
    frame_event = 1'b1;
    @(negedge clk); frame_event = 1'b0; int_hold = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (bus_starts !== s0 || irq_count !== c0) begin
      miscompares++;
      $display("FAIL irq_disabled: bus starts %0d irqs %0d required 0 0", bus_starts - s0, irq_count - c0);
    end
    irq_en = 1'b1;
    repeat (12) @(negedge clk);
    vectors++;
    if (irq_reads - r0 !== 1 || irq_count - c0 !== 1 || irq_last !== 32'h1) begin
      miscompares++;
      $display("FAIL irq_enabled_once: reads=%0d irqs=%0d pending=%h required 1 1 00000001",
               irq_reads - r0, irq_count - c0, irq_last);
    end
    int_hold = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_cycle();
    logic fr, got, err; logic [31:0] rd; int acc, det, rc; logic [32:0] exp;
    @(negedge clk);
    mac_stall = 1'b1;
    send_cmd(1'b0, ADR_CONFIG0, 32'h0, fr, acc);
    rc = rsp_count;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: cyc=%b stb=%b ready=%b required 0 0 0", wb_cyc_o, wb_stb_o, cmd_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1; mac_stall = 1'b0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1 || rsp_count !== rc) begin
      miscompares++;
      $display("FAIL reset_recover: ready=%b extra rsp=%0d required 1 0", cmd_ready, rsp_count - rc);
    end
    @(negedge clk); stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (wb_cyc_o !== 1'b0 || rsp_count !== rc) begin
      miscompares++;
      $display("FAIL stray_ack: cyc=%b extra rsp=%0d required 0 0", wb_cyc_o, rsp_count - rc);
    end
    exp_q.push_back({1'b0, 32'h0000_0001});
    send_cmd(1'b0, ADR_CONFIG0, 32'h0, fr, acc);
    wait_rsp(got, rd, err, det);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || {err, rd} !== exp || det - acc + 1 !== 3) begin
      miscompares++;
      $display("FAIL post_reset_read: valid=%b err=%b rdata=%h lat=%0d required 1 0 00000001 3",
               got, err, rd, det - acc + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic fr, got, err; logic [31:0] rd; int acc, det, s0;
    logic [7:0]  adrs [0:5];
    logic [31:0] shadow [0:63];
    logic [32:0] exp;
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    s0 = bus_starts;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      logic we; logic [31:0] d;
      we = (i < 6);
      if (we) begin
        adrs[i] = {$urandom_range(8, 15), 2'b00};
        d = $urandom;
        shadow[adrs[i][7:2]] = d;
        exp_q.push_back({1'b0, 32'h0});
        send_cmd(1'b1, adrs[i], d, fr, acc);
      end else begin
        exp_q.push_back({1'b0, shadow[adrs[i-6][7:2]]});
        send_cmd(1'b0, adrs[i-6], 32'h0, fr, acc);
      end
      wait_rsp(got, rd, err, det);
      exp = exp_q.pop_front();
      vectors++;
      if (!got || {err, rd} !== exp) begin
        miscompares++;
        $display("FAIL b2b_rsp[%0d]: valid=%b err=%b rdata=%h required 1 %b %h",
                 i, got, err, rd, exp[32], exp[31:0]);
      end
    end
    @(negedge clk);
    vectors++;
    if (bus_starts - s0 !== 12) begin
      miscompares++;
      $display("FAIL b2b_gaps: %0d separate cycles required 12", bus_starts - s0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read_latency();
    test_timeout();
    test_irq_vs_cmd();
    test_irq_enable();
    test_reset_mid_cycle();
    test_back_to_back();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xge_wb_initiator.md
# xge_wb_initiator

Wishbone classic single-transfer initiator that drives the xge_mac register port (wb_cyc_i/wb_stb_i/wb_we_i/wb_adr_i/wb_dat_i → wb_ack_o/wb_dat_o/wb_int_o). It converts a simple valid/ready command channel into one Wishbone cycle at a time, returns the read data or a timeout error, and services wb_int_o by automatically reading the MAC interrupt-pending register. It sits beside the MAC on the 156.25 MHz core clock and replaces ad-hoc bus poking in the environment.

## Interface
- TIMEOUT_CYC, 64: cycles a Wishbone cycle may wait for wb_ack_o before it is aborted (2..65535)
- INT_PEND_ADR, 8'h08: address read automatically on interrupt
- clk_156m25  in  1  core clock; all logic on rising edge
- reset_156m25_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  8  register address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle pulse: command completed
- rsp_rdata  out  32  read data (0 for writes and timeouts)
- rsp_err  out  1  qualifies rsp_valid: cycle timed out
- irq_en  in  1  enable automatic interrupt service
- irq_valid  out  1  one-cycle pulse: interrupt-pending word captured
- irq_pending  out  32  captured interrupt-pending word
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone controls
- wb_adr_o  out  8  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_int_i  in  1  MAC interrupt (level)

## Operation
- States: IDLE, CMD_CYC, CMD_RSP, IRQ_CYC.
- Interrupt arm: irq_armed sets whenever wb_int_i = 0; an interrupt request is raised when wb_int_i = 1, irq_en = 1 and irq_armed = 1.
- IDLE: if interrupt request → IRQ_CYC, clear irq_armed, drive adr = INT_PEND_ADR, we = 0. Otherwise cmd_ready = 1; on cmd_valid & cmd_ready latch we/adr/wdata → CMD_CYC. The interrupt request wins over a simultaneous command (cmd_ready is 0 that cycle).
- CMD_CYC/IRQ_CYC: cyc = stb = 1, adr/we/dat held stable. Timeout counter clears on entry and increments each cycle.
- Ack sampled in CMD_CYC: capture wb_dat_i (reads) or 0 (writes) → CMD_RSP, rsp_err = 0.
- Counter reaches TIMEOUT_CYC−1 without ack in CMD_CYC: rsp_rdata = 0, rsp_err = 1 → CMD_RSP.
- Ack takes precedence over timeout in the same cycle.
- CMD_RSP: rsp_valid = 1 for exactly one cycle → IDLE. There is no back-pressure on rsp.
- IRQ_CYC on ack: irq_pending = wb_dat_i, irq_valid pulse next cycle → IDLE. On timeout: irq_valid is not pulsed, → IDLE, irq_armed stays cleared.
- Write data to wb_dat_o is 0 on every read cycle.

## Timing
- Reset (async assert, sync release): IDLE; cmd_ready = 0 during reset, 1 first cycle after; all other outputs 0; irq_armed = 0.
- Command accepted at edge N → cyc/stb high from N+1 (registered outputs).
- Ack sampled at edge M → cyc/stb low after M+1; rsp_valid high the cycle after M+1; rsp_rdata stable with it. Zero-wait-state read: accept to rsp_valid = 3 cycles.
- cyc/stb never assert for back-to-back transfers without at least one low cycle (IDLE).
- Reset mid-cycle: cyc/stb drop asynchronously; the in-flight command is lost with no rsp.
- wb_ack_i outside a cycle is ignored.

## Structure
- Shared package xge_wb_pkg: state enum, register address constants (CONFIG0 8'h00, INT_PENDING 8'h08, INT_STATUS 8'h0C, INT_MASK 8'h10), default TIMEOUT_CYC.
- Single module. The timeout counter is inline, width $clog2(TIMEOUT_CYC+1).

## Test plan
- Write cmd adr 8'h00, wdata 32'h0000_0001, MAC acks → wb_we_o = 1, wb_dat_o = 32'h1 during cycle; rsp_valid, rsp_err = 0, rsp_rdata = 0.
- Read adr 8'h00 after the write → rsp_rdata = 32'h0000_0001, 3 cycles from accept to rsp_valid with zero-wait ack.
- Read adr 8'hFC with ack forced low, TIMEOUT_CYC = 16 → cyc/stb high for exactly 16 cycles, rsp_err = 1, rsp_rdata = 0.
- Loopback frame with INT_MASK = 32'hFFFF_FFFF causing wb_int_o: assert cmd_valid the same cycle → IRQ read of 8'h08 first, irq_valid with nonzero irq_pending, then the command completes. A single interrupt produces no second read until wb_int_o falls.
- Async reset asserted mid-read → cyc/stb 0 immediately, no rsp_valid; after release cmd_ready = 1 and the next read completes normally.
- irq_en = 0 with wb_int_o high → no bus activity and no irq_valid; set irq_en = 1 → exactly one auto-read.
